ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same ps2c/ps2d lines the keyboard receiver uses. It runs the full host request sequence: clock inhibit, request-to-send, 11-bit frame clocked by the device, and the device acknowledge bit. It sits beside the keyboard receiver under main_control. While a transfer is active it asserts `rx_inhibit` so the receiver ignores the bus. Lines are open-drain; top level maps `*_drive_low` to tri-state pads.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 144 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes, frame geometry.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  localparam int FRAME_EDGES = 11;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-flop synchronizer, FILTER_LEN-sample glitch filter, 1->0 edge pulse.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_50,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync2_q, level_q, fall_q;
  logic [CNT_W-1:0] cnt_q;

  // The run counter restarts whenever the synchronized sample agrees with the filtered level.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        fall_q  <= level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked frame, ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       ack_ok,
  output logic       tx_err,
  output logic       rx_inhibit,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low
);

  localparam int MAX_IR  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_CYC = (TIMEOUT_CYCLES > MAX_IR) ? TIMEOUT_CYCLES : MAX_IR;
  localparam int CNT_W   = cnt_width(MAX_CYC);
  localparam int EDGE_W  = cnt_width(FRAME_EDGES);
  localparam logic [CNT_W-1:0]  INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REQ_LAST  = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [EDGE_W-1:0] STOP_EDGE = EDGE_W'(FRAME_EDGES - 1);

  ps2_tx_state_t     state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q;
  logic [9:0]        shreg_q, shreg_d;
  logic tx_ready_q, tx_done_q, ack_ok_q, tx_err_q, rx_inhibit_q, c_low_q, d_low_q;
  logic c_level, c_fall, d_level, d_fall_unused;
  logic accept, timeout, shift_en;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk_50(clk_50), .reset(reset), .line_i(ps2c_in), .level_o(c_level), .fall_o(c_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk_50(clk_50), .reset(reset), .line_i(ps2d_in), .level_o(d_level), .fall_o(d_fall_unused)
  );

  assign accept   = (state_q == IDLE) && tx_start && tx_ready_q;
  assign timeout  = ((state_q == SHIFT) || (state_q == WAIT_IDLE)) && (cnt_q == TO_LAST);
  assign shift_en = (state_q == SHIFT) && c_fall && !timeout && (edge_q != STOP_EDGE);
  assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign shreg_d  = accept ? {1'b1, ~^tx_data, tx_data} : {1'b0, shreg_q[9:1]};

  // Frame bits {stop, odd parity, data}; bit 0 is the next one put on ps2d.
  always_ff @(posedge clk_50) begin
    if (accept || shift_en) shreg_q <= shreg_d;
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      edge_q       <= '0;
      tx_ready_q   <= 1'b1;
      tx_done_q    <= 1'b0;
      ack_ok_q     <= 1'b0;
      tx_err_q     <= 1'b0;
      rx_inhibit_q <= 1'b0;
      c_low_q      <= 1'b0;
      d_low_q      <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q      <= '0;
          tx_ready_q <= 1'b1;
          if (accept) begin
            state_q      <= INHIBIT;
            edge_q       <= '0;
            tx_ready_q   <= 1'b0;
            rx_inhibit_q <= 1'b1;
            ack_ok_q     <= 1'b0;
            c_low_q      <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            cnt_q   <= '0;
            d_low_q <= 1'b1;
            state_q <= REQ;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        REQ: begin
          if (cnt_q == REQ_LAST) begin
            cnt_q   <= '0;
            c_low_q <= 1'b0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        SHIFT, WAIT_IDLE: begin
          cnt_q <= cnt_d;
          // Timeout wins over a coincident clock edge.
          if (timeout) begin
            c_low_q      <= 1'b0;
            d_low_q      <= 1'b0;
            tx_err_q     <= 1'b1;
            rx_inhibit_q <= 1'b0;
            state_q      <= IDLE;
          end else if ((state_q == SHIFT) && c_fall) begin
            edge_q <= edge_q + EDGE_W'(1);
            if (edge_q == STOP_EDGE) begin
              ack_ok_q <= ~d_level;
              c_low_q  <= 1'b0;
              d_low_q  <= 1'b0;
              state_q  <= WAIT_IDLE;
            end else begin
              d_low_q <= ~shreg_q[0];
            end
          end else if ((state_q == WAIT_IDLE) && c_level && d_level) begin
            tx_done_q    <= 1'b1;
            rx_inhibit_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready       = tx_ready_q;
  assign tx_done        = tx_done_q;
  assign ack_ok         = ack_ok_q;
  assign tx_err         = tx_err_q;
  assign rx_inhibit     = rx_inhibit_q;
  assign ps2c_drive_low = c_low_q;
  assign ps2d_drive_low = d_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus, clocking device model, completion scoreboard.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int REQ  = 10;
  localparam int TO   = 3000;
  localparam int FLT  = 4;
  localparam int HALF = 40;

  typedef struct packed {
    logic is_err;
    logic ack;
  } exp_t;

  logic       clk_50, reset, tx_start;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, ack_ok, tx_err, rx_inhibit;
  logic       ps2c_drive_low, ps2d_drive_low;
  logic       dev_c_low, dev_d_low, glitch_c;
  wire        ps2c_in = ~(ps2c_drive_low | dev_c_low | glitch_c);
  wire        ps2d_in = ~(ps2d_drive_low | dev_d_low);

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FLT)
  ) dut (
    .clk_50(clk_50), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .ack_ok(ack_ok), .tx_err(tx_err),
    .rx_inhibit(rx_inhibit), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_drive_low(ps2c_drive_low), .ps2d_drive_low(ps2d_drive_low)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Device side of one frame; abort_after>0 stops after that falling edge.
  task automatic device(input logic [7:0] data, input logic ack, input int glitch_bit,
                        input int abort_after);
    logic exp_bits [11];
    int   n;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = data[i];
    exp_bits[9]  = (($countones(data) % 2) == 0);
    exp_bits[10] = 1'b1;
    n = 0;
    while (ps2c_in !== 1'b0 && n < 200) begin @(negedge clk_50); n++; end
    check("inhibit_seen", ps2c_in, 0);
    n = 0;
    while (ps2c_in !== 1'b1 && n < INH + REQ + 50) begin @(negedge clk_50); n++; end
    check("c_low_len", n, INH + REQ);
    check("bit0_start", ps2d_in, exp_bits[0]);
    repeat (HALF) @(negedge clk_50);
    for (int k = 1; k <= 10; k++) begin
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk_50);
      dev_c_low = 1'b0;
      if (k == abort_after) return;
      check($sformatf("bit%0d", k), ps2d_in, exp_bits[k]);
      if (k == glitch_bit) begin
        repeat (HALF / 2) @(negedge clk_50);
        glitch_c = 1'b1;
        repeat (3) @(negedge clk_50);
        glitch_c = 1'b0;
        repeat (HALF - HALF / 2 - 3) @(negedge clk_50);
      end else begin
        repeat (HALF) @(negedge clk_50);
      end
    end
    dev_d_low = ack;
    repeat (HALF / 2) @(negedge clk_50);
    dev_c_low = 1'b1;
    repeat (HALF) @(negedge clk_50);
    dev_c_low = 1'b0;
    repeat (HALF / 2) @(negedge clk_50);
    dev_d_low = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] data);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin @(negedge clk_50); n++; end
    check("ready_before_start", tx_ready, 1);
    tx_data  = data;
    tx_start = 1'b1;
    @(negedge clk_50);
    tx_start = 1'b0;
    check("accept", {tx_ready, rx_inhibit, ps2c_drive_low, ps2d_drive_low}, 4'b0110);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 4000) begin @(negedge clk_50); n++; end
    check("ready_after_frame", tx_ready, 1);
    repeat (5) @(negedge clk_50);
    check("idle_lines", {rx_inhibit, ps2c_drive_low, ps2d_drive_low}, 0);
  endtask

  task automatic send(input logic [7:0] data, input logic ack, input int glitch_bit);
    exp_q.push_back('{1'b0, ack});
    start_tx(data);
    device(data, ack, glitch_bit, 0);
    wait_ready();
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50);
      if (tx_done === 1'b1 || tx_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {tx_done, tx_err}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {tx_done, tx_err}, {~e.is_err, e.is_err});
          if (!e.is_err) check("ack_ok", ack_ok, e.ack);
        end
        @(negedge clk_50);
        check("pulse_width", {tx_done, tx_err}, 2'b00);
        check("ready_after_pulse", tx_ready, 1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] rd;
    logic       ra;
    int         rg;
    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    dev_c_low = 1'b0; dev_d_low = 1'b0; glitch_c = 1'b0;
    repeat (3) @(negedge clk_50);
    check("rst_ready", tx_ready, 1);
    check("rst_outs", {tx_done, tx_err, ack_ok, rx_inhibit, ps2c_drive_low, ps2d_drive_low}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_50);

    send(PS2_CMD_SET_LEDS, 1'b1, 0);
    send(8'h07, 1'b0, 0);
    send(8'hC3, 1'b1, 4);

    // Device never clocks.
    exp_q.push_back('{1'b1, 1'b0});
    start_tx(8'h55);
    n = 0;
    while (ps2c_drive_low !== 1'b0 && n < INH + REQ + 50) begin @(negedge clk_50); n++; end
    n = 0;
    while (tx_err !== 1'b1 && n < TO + 50) begin @(negedge clk_50); n++; end
    check("timeout_len", n, TO);
    check("timeout_lines", {ps2c_drive_low, ps2d_drive_low}, 0);
    wait_ready();

    // Reset after the fifth falling edge (data[4]=0 so ps2d is being pulled).
    start_tx(8'hA5);
    device(8'hA5, 1'b0, 0, 5);
    repeat (10) @(negedge clk_50);
    check("pre_reset_d_low", ps2d_drive_low, 1);
    #2 reset = 1'b1;
    #1 check("reset_lines", {ps2c_drive_low, ps2d_drive_low}, 0);
    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    @(negedge clk_50);
    check("ready_after_reset", {tx_ready, rx_inhibit}, 2'b10);

    // Start request while busy must be ignored.
    exp_q.push_back('{1'b0, 1'b1});
    start_tx(8'h3C);
    fork
      device(8'h3C, 1'b1, 0, 0);
      begin
        repeat (300) @(negedge clk_50);
        tx_data  = PS2_CMD_RESET;
        tx_start = 1'b1;
        @(negedge clk_50);
        tx_start = 1'b0;
      end
    join
    wait_ready();

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      rg = int'($urandom_range(0, 9));
      send(rd, ra, rg);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk_50); n++; end
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
